// File: rtl/pc_next_unit.sv
// Program-counter sequencing for the single-cycle CPU. Holds the PC, which updates on the
// falling clock edge, and selects either pc+4 or a PC-relative branch target as the next PC.

module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// Builds the upper half from the gated sign bit, so ext=0 always yields zero-extension.
module imm_extender (
  input  logic        sign,
  input  logic [15:0] imm16,
  output logic [31:0] imm_ext
);
  assign imm_ext = {{16{sign}}, imm16};
endmodule

// The select input is a full word; any nonzero value picks input b.
module mux_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] sel,
  output logic [31:0] y
);
  assign y = (sel != 32'd0) ? b : a;
endmodule

module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nPC_sel,
  input  logic        ext,
  input  logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] imm_ext,
  output logic [31:0] branch_target,
  output logic [31:0] pc_next
);

  logic        sign;
  logic [31:0] mux_sel;

  and_gate u_sign_gate (
    .a (ext),
    .b (imm16[15]),
    .y (sign)
  );

  imm_extender u_extender (
    .sign    (sign),
    .imm16   (imm16),
    .imm_ext (imm_ext)
  );

  // Carry-out is dropped on both adders; the PC wraps silently modulo 2^32.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign mux_sel       = {31'b0, nPC_sel};

  mux_32 u_mux (
    .a   (pc_plus4),
    .b   (branch_target),
    .sel (mux_sel),
    .y   (pc_next)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: reset, sequential flow, forward/backward branches,
// extender modes, select changes between edges, and address wrap on a zero-reset instance.

module tb_pc_next_unit;

  logic        clk;
  logic        rst;
  logic        nPC_sel;
  logic        ext;
  logic [15:0] imm16;

  logic [31:0] pc, pc_plus4, imm_ext, branch_target, pc_next;
  logic [31:0] z_pc, z_pc_plus4, z_imm_ext, z_branch_target, z_pc_next;

  int checks = 0;
  int errors = 0;

  pc_next_unit dut (
    .clk           (clk),
    .rst           (rst),
    .nPC_sel       (nPC_sel),
    .ext           (ext),
    .imm16         (imm16),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .imm_ext       (imm_ext),
    .branch_target (branch_target),
    .pc_next       (pc_next)
  );

  // Second instance resets to zero so a short backward branch reaches the top of memory.
  pc_next_unit #(.RESET_PC(32'h00000000)) dut_zero (
    .clk           (clk),
    .rst           (rst),
    .nPC_sel       (nPC_sel),
    .ext           (ext),
    .imm16         (imm16),
    .pc            (z_pc),
    .pc_plus4      (z_pc_plus4),
    .imm_ext       (z_imm_ext),
    .branch_target (z_branch_target),
    .pc_next       (z_pc_next)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic apply_stimulus(input logic sel, input logic e, input logic [15:0] imm);
    nPC_sel = sel;
    ext     = e;
    imm16   = imm;
  endtask

  // Moves to just after the next falling edge, where the PC has updated.
  task automatic fall_edge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    #1;
    check_output("reset_pc", pc, 32'h00400020);
    fall_edge();
    fall_edge();
    check_output("reset_hold", pc, 32'h00400020);

    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("release_no_update", pc, 32'h00400020);
    check_output("pc_plus4_reset", pc_plus4, 32'h00400024);

    fall_edge();
    check_output("seq_1", pc, 32'h00400024);
    check_output("seq_1_plus4", pc_plus4, 32'h00400028);

    apply_stimulus(1'b1, 1'b1, 16'h0003);
    #1;
    check_output("fwd_imm_ext", imm_ext, 32'h00000003);
    check_output("fwd_target", branch_target, 32'h00400034);
    check_output("fwd_pc_next", pc_next, 32'h00400034);
    fall_edge();
    check_output("fwd_pc", pc, 32'h00400034);

    apply_stimulus(1'b1, 1'b1, 16'hFFFF);
    #1;
    check_output("back_imm_ext", imm_ext, 32'hFFFFFFFF);
    check_output("back_target", branch_target, 32'h00400034);
    for (int i = 0; i < 3; i++) begin
      fall_edge();
      check_output("self_loop", pc, 32'h00400034);
    end

    apply_stimulus(1'b0, 1'b1, 16'hFFFF);
    fall_edge();
    check_output("seq_2", pc, 32'h00400038);
    fall_edge();
    fall_edge();
    check_output("seq_3", pc, 32'h00400040);

    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset", pc, 32'h00400020);
    fall_edge();
    check_output("reset_wins_edge", pc, 32'h00400020);
    @(posedge clk);
    #1;
    rst = 1'b0;

    apply_stimulus(1'b0, 1'b1, 16'h8000);
    #1;
    check_output("ext_sign", imm_ext, 32'hFFFF8000);
    check_output("ext_sign_target", branch_target, 32'h003E0024);
    apply_stimulus(1'b1, 1'b0, 16'h8000);
    #1;
    check_output("ext_zero", imm_ext, 32'h00008000);
    check_output("ext_zero_target", branch_target, 32'h00420024);
    fall_edge();
    check_output("ext_zero_pc", pc, 32'h00420024);

    // Select changes between edges must not disturb the registered PC.
    #1 nPC_sel = 1'b0;
    #1 nPC_sel = 1'b1;
    #1 nPC_sel = 1'b0;
    #1;
    check_output("toggle_hold", pc, 32'h00420024);
    check_output("toggle_pc_next", pc_next, 32'h00420028);
    fall_edge();
    check_output("toggle_pc", pc, 32'h00420028);

    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("zero_reset", z_pc, 32'h00000000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(1'b1, 1'b1, 16'hFFFE);
    #1;
    check_output("wrap_imm_ext", z_imm_ext, 32'hFFFFFFFE);
    check_output("wrap_target", z_branch_target, 32'hFFFFFFFC);
    fall_edge();
    check_output("wrap_branch_pc", z_pc, 32'hFFFFFFFC);
    check_output("main_back_pc", pc, 32'h0040001C);
    check_output("wrap_plus4", z_pc_plus4, 32'h00000000);
    apply_stimulus(1'b0, 1'b1, 16'hFFFE);
    fall_edge();
    check_output("wrap_pc", z_pc, 32'h00000000);
    check_output("main_seq_pc", pc, 32'h00400020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
